sfx_event_queue: RTL and testbench

//  Upstream stage of the audio block. Captures single-cycle game-controller event pulses and

---
 rtl/sfx_pkg.sv | 38 +++
 rtl/sfx_fifo.sv | 78 +++++++
 rtl/sfx_event_queue.sv | 160 ++++++++++++++++
 tb/tb_sfx_event_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Purpose : shared event codes, FSM states and helpers for the SFX event queue.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
// Contents: sfx_code_t matches the audio block's sfx_type encoding (NONE=0, JUMP=1, DEATH=2, HIGH=3).
package sfx_pkg;

    typedef enum logic [1:0] {
        SFX_NONE  = 2'd0,
        SFX_JUMP  = 2'd1,
        SFX_DEATH = 2'd2,
        SFX_HIGH  = 2'd3
    } sfx_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } sfx_state_t;

    // Collapse simultaneous pulses into one code: death > highscore > jump.
    function automatic sfx_code_t sfx_prio(input logic jump, input logic death, input logic high);
        sfx_code_t code;
        code = SFX_NONE;
        if (death) begin
            code = SFX_DEATH;
        end else if (high) begin
            code = SFX_HIGH;
        end else if (jump) begin
            code = SFX_JUMP;
        end
        return code;
    endfunction

    function automatic int sfx_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sfx_fifo.sv
// Purpose : small synchronous FIFO of sfx_code_t with flush.
// Latency : push visible at head/level after one edge; pop frees a slot on the same edge.
// Backpr. : push accepted when not full, or full with a same-edge pop, or together with flush.
// Ports   : clk, rst (sync, active-high); push_i/push_dat_i, pop_i, flush_i in;
//           head_o (oldest), newest_o (last written), level_o, full_o, empty_o out.
//           Flush with push leaves exactly the pushed entry in the FIFO.
module sfx_fifo
    import sfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  sfx_code_t              push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output sfx_code_t              head_o,
    output sfx_code_t              newest_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    sfx_code_t     mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] newest_idx;

    // Pointers carry one extra MSB: equal low bits with differing MSB means full.
    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o    = wr_q - rd_q;
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (flush_i || !full_o || pop_ok);
    assign wr_idx     = flush_i ? '0 : wr_q[AW-1:0];
    assign newest_idx = wr_q[AW-1:0] - 1'b1;
    assign head_o     = mem_q[rd_q[AW-1:0]];
    assign newest_o   = mem_q[newest_idx];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            rd_d = '0;
            wr_d = {{AW{1'b0}}, push_ok};
        end else begin
            if (push_ok) begin
                wr_d = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx] <= push_dat_i;
        end
    end

endmodule

// File: rtl/sfx_event_queue.sv
// Purpose : capture game event pulses, queue them, replay each as a held one-hot level for audio.
// Latency : pulse at edge N into idle/empty queue -> output high after edge N+1 for HOLD_CYCLES,
//           then GAP_CYCLES+1 low cycles before the next event.
// Backpr. : none upstream; non-death push into a full queue is dropped with a 1-cycle overflow.
// Ports   : clk, rst (sync, active-high), game_running, jump_pulse, death_pulse, highscore_pulse in;
//           event_jump/event_death/event_highscore (registered, one-hot or zero), queue_level,
//           overflow out.
// Config  : define SFX_DEDUP_EN to discard a non-death push equal to the newest queued code
//           (or to the code being held when the queue is empty).
module sfx_event_queue
    import sfx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1088,
    parameter int GAP_CYCLES  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_running,
    input  logic                   jump_pulse,
    input  logic                   death_pulse,
    input  logic                   highscore_pulse,
    output logic                   event_jump,
    output logic                   event_death,
    output logic                   event_highscore,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic                   overflow
);
    localparam int CW = $clog2(sfx_max(HOLD_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

`ifdef SFX_DEDUP_EN
    localparam logic DEDUP_EN = 1'b1;
`else
    localparam logic DEDUP_EN = 1'b0;
`endif

    sfx_state_t    state_q;
    logic [CW-1:0] cnt_q;
    sfx_code_t     cur_q;
    logic          ev_jump_q;
    logic          ev_death_q;
    logic          ev_high_q;
    logic          overflow_q;

    sfx_code_t     cap_code;
    sfx_code_t     fifo_head;
    sfx_code_t     fifo_newest;
    logic          fifo_full;
    logic          fifo_empty;
    logic          death_cap;
    logic          pop_en;
    logic          dup_hit;
    logic          normal_push;
    logic          push_drop;
    logic          push_en;
    logic          abort_cur;

    assign cap_code  = sfx_prio(jump_pulse & game_running, death_pulse, highscore_pulse);
    assign death_cap = (cap_code == SFX_DEATH);

    // A death this cycle flushes the queue, so the old head must not be popped alongside it.
    assign pop_en = (state_q == ST_IDLE) && !fifo_empty && !death_cap;

    // Duplicate detection is computed in both builds and gated by the build switch.
    always_comb begin
        dup_hit = 1'b0;
        if (!fifo_empty) begin
            dup_hit = (cap_code == fifo_newest);
        end else if (state_q == ST_HOLD) begin
            dup_hit = (cap_code == cur_q);
        end
        dup_hit = dup_hit && DEDUP_EN;
    end

    assign normal_push = (cap_code != SFX_NONE) && !death_cap && !dup_hit;
    assign push_drop   = normal_push && fifo_full && !pop_en;
    assign push_en     = death_cap || (normal_push && !push_drop);

    // A death preempts any non-death presentation; a death over a death simply re-queues.
    assign abort_cur = death_cap && (cur_q != SFX_DEATH);

    sfx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_en),
        .push_dat_i (cap_code),
        .pop_i      (pop_en),
        .flush_i    (death_cap),
        .head_o     (fifo_head),
        .newest_o   (fifo_newest),
        .level_o    (queue_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= SFX_NONE;
            ev_jump_q  <= 1'b0;
            ev_death_q <= 1'b0;
            ev_high_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_drop;
            case (state_q)
                ST_IDLE: begin
                    if (pop_en) begin
                        cur_q      <= fifo_head;
                        cnt_q      <= '0;
                        state_q    <= ST_HOLD;
                        ev_jump_q  <= (fifo_head == SFX_JUMP);
                        ev_death_q <= (fifo_head == SFX_DEATH);
                        ev_high_q  <= (fifo_head == SFX_HIGH);
                    end
                end
                ST_HOLD: begin
                    if (abort_cur || (cnt_q == HOLD_LAST)) begin
                        state_q    <= abort_cur ? ST_IDLE : ST_GAP;
                        cur_q      <= abort_cur ? SFX_NONE : cur_q;
                        cnt_q      <= '0;
                        ev_jump_q  <= 1'b0;
                        ev_death_q <= 1'b0;
                        ev_high_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (abort_cur || (cnt_q == GAP_LAST)) begin
                        state_q <= ST_IDLE;
                        cur_q   <= SFX_NONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cur_q      <= SFX_NONE;
                    cnt_q      <= '0;
                    ev_jump_q  <= 1'b0;
                    ev_death_q <= 1'b0;
                    ev_high_q  <= 1'b0;
                end
            endcase
        end
    end

    assign event_jump      = ev_jump_q;
    assign event_death     = ev_death_q;
    assign event_highscore = ev_high_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_sfx_event_queue.sv
module tb_sfx_event_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_running = 1'b0;
    logic       jump_pulse = 1'b0;
    logic       death_pulse = 1'b0;
    logic       highscore_pulse = 1'b0;
    logic       event_jump;
    logic       event_death;
    logic       event_highscore;
    logic [2:0] queue_level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] EV_JUMP  = 3'b001;
    localparam logic [2:0] EV_DEATH = 3'b010;
    localparam logic [2:0] EV_HIGH  = 3'b100;

    sfx_event_queue #(
        .DEPTH       (4),
        .HOLD_CYCLES (1088),
        .GAP_CYCLES  (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .game_running    (game_running),
        .jump_pulse      (jump_pulse),
        .death_pulse     (death_pulse),
        .highscore_pulse (highscore_pulse),
        .event_jump      (event_jump),
        .event_death     (event_death),
        .event_highscore (event_highscore),
        .queue_level     (queue_level),
        .overflow        (overflow)
    );

    always #10 clk = ~clk;

    // Observer: records each high window of the event outputs as {code, start, length}.
    typedef struct {
        logic [2:0] ev;
        int         start;
        int         len;
    } win_t;

    win_t       wins[$];
    int         cyc = 0;
    int         run_start = 0;
    int         multi_hot = 0;
    int         ovf_cnt = 0;
    logic [2:0] prev_ev = 3'b000;

    always @(negedge clk) begin
        logic [2:0] now_ev;
        win_t       w;
        now_ev = {event_highscore, event_death, event_jump};
        if ($countones(now_ev) > 1) multi_hot++;
        if (overflow === 1'b1) ovf_cnt++;
        if (now_ev != prev_ev) begin
            if (prev_ev != 3'b000) begin
                w.ev    = prev_ev;
                w.start = run_start;
                w.len   = cyc - run_start;
                wins.push_back(w);
            end
            run_start = cyc;
        end
        prev_ev = now_ev;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic j, input logic d, input logic h);
        jump_pulse      = j;
        death_pulse     = d;
        highscore_pulse = h;
        tick();
        jump_pulse      = 1'b0;
        death_pulse     = 1'b0;
        highscore_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(3);
        total++;
        if ({event_highscore, event_death, event_jump} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs: got %b expected 000", {event_highscore, event_death, event_jump});
        end
        total++;
        if (queue_level !== 3'd0) begin
            bad++; $display("FAIL reset_level: got %0d expected 0", queue_level);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
        rst = 1'b0;
        run(2);
    endtask

    task automatic test_single_jump();
        int base;
        base = wins.size();
        game_running = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        total++;
        if (queue_level !== 3'd1 || event_jump !== 1'b0) begin
            bad++; $display("FAIL jump_capture: level=%0d jump=%b expected level=1 jump=0", queue_level, event_jump);
        end
        tick();
        total++;
        if (event_jump !== 1'b1 || queue_level !== 3'd0) begin
            bad++; $display("FAIL jump_latency: jump=%b level=%0d expected jump=1 level=0", event_jump, queue_level);
        end
        run(500);
        pulse(1'b0, 1'b0, 1'b1);
        total++;
        if (queue_level !== 3'd1) begin
            bad++; $display("FAIL jump_queue_second: level=%0d expected 1", queue_level);
        end
        run(1900);
        total++;
        if (wins.size() - base !== 2) begin
            bad++; $display("FAIL jump_windows: got %0d expected 2", wins.size() - base);
        end else begin
            total++;
            if (wins[base].ev !== EV_JUMP || wins[base].len !== 1088) begin
                bad++; $display("FAIL jump_window1: code=%b len=%0d expected 001 1088", wins[base].ev, wins[base].len);
            end
            total++;
            if (wins[base+1].ev !== EV_HIGH || wins[base+1].len !== 1088) begin
                bad++; $display("FAIL jump_window2: code=%b len=%0d expected 100 1088", wins[base+1].ev, wins[base+1].len);
            end
            total++;
            if (wins[base+1].start - (wins[base].start + wins[base].len) !== 65) begin
                bad++; $display("FAIL jump_gap: got %0d expected 65",
                                wins[base+1].start - (wins[base].start + wins[base].len));
            end
        end
    endtask

    task automatic test_same_cycle();
        int base;
        base = wins.size();
        game_running = 1'b1;
        pulse(1'b1, 1'b1, 1'b1);
        total++;
        if (queue_level !== 3'd1) begin
            bad++; $display("FAIL same_cycle_level: got %0d expected 1", queue_level);
        end
        run(1300);
        total++;
        if (wins.size() - base !== 1) begin
            bad++; $display("FAIL same_cycle_windows: got %0d expected 1", wins.size() - base);
        end else begin
            total++;
            if (wins[base].ev !== EV_DEATH || wins[base].len !== 1088) begin
                bad++; $display("FAIL same_cycle_code: code=%b len=%0d expected 010 1088", wins[base].ev, wins[base].len);
            end
        end
    endtask

    task automatic test_overflow();
        int base;
        int ovf0;
        int max_level;
        int exp_level;
        int exp_ovf;
        int exp_wins;
        logic ovf_at_fifth;
`ifdef SFX_DEDUP_EN
        exp_level = 1; exp_ovf = 0; exp_wins = 2;
`else
        exp_level = 4; exp_ovf = 1; exp_wins = 5;
`endif
        base = wins.size();
        ovf0 = ovf_cnt;
        max_level = 0;
        ovf_at_fifth = 1'b0;
        game_running = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            pulse(1'b0, 1'b0, 1'b1);
            if (int'(queue_level) > max_level) max_level = int'(queue_level);
            if (k == 4) ovf_at_fifth = overflow;
            run(9);
        end
        total++;
        if (max_level !== exp_level) begin
            bad++; $display("FAIL ovf_level: got %0d expected %0d", max_level, exp_level);
        end
        total++;
        if (ovf_at_fifth !== (exp_ovf == 1)) begin
            bad++; $display("FAIL ovf_fifth: got %b expected %0d", ovf_at_fifth, exp_ovf);
        end
        run(6000);
        total++;
        if (ovf_cnt - ovf0 !== exp_ovf) begin
            bad++; $display("FAIL ovf_count: got %0d expected %0d", ovf_cnt - ovf0, exp_ovf);
        end
        total++;
        if (wins.size() - base !== exp_wins) begin
            bad++; $display("FAIL ovf_windows: got %0d expected %0d", wins.size() - base, exp_wins);
        end else begin
            for (int i = 1; i < exp_wins; i++) begin
                total++;
                if (wins[base+i].ev !== EV_HIGH || wins[base+i].len !== 1088) begin
                    bad++; $display("FAIL ovf_present%0d: code=%b len=%0d expected 100 1088", i, wins[base+i].ev, wins[base+i].len);
                end
            end
        end
    endtask

    task automatic test_death_preempt();
        int base;
        int exp_level;
`ifdef SFX_DEDUP_EN
        exp_level = 1;
`else
        exp_level = 2;
`endif
        base = wins.size();
        game_running = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        run(3);
        pulse(1'b1, 1'b0, 1'b0);
        total++;
        if (event_highscore !== 1'b1 || int'(queue_level) !== exp_level) begin
            bad++; $display("FAIL preempt_setup: high=%b level=%0d expected high=1 level=%0d", event_highscore, queue_level, exp_level);
        end
        pulse(1'b0, 1'b1, 1'b0);
        total++;
        if ({event_highscore, event_death, event_jump} !== 3'b000 || queue_level !== 3'd1) begin
            bad++; $display("FAIL preempt_abort: outs=%b level=%0d expected outs=000 level=1",
                            {event_highscore, event_death, event_jump}, queue_level);
        end
        tick();
        total++;
        if (event_death !== 1'b1 || queue_level !== 3'd0) begin
            bad++; $display("FAIL preempt_death: death=%b level=%0d expected death=1 level=0", event_death, queue_level);
        end
        run(1400);
        total++;
        if (wins.size() - base !== 2) begin
            bad++; $display("FAIL preempt_windows: got %0d expected 2", wins.size() - base);
        end else begin
            total++;
            if (wins[base].ev !== EV_HIGH || wins[base+1].ev !== EV_DEATH || wins[base+1].len !== 1088) begin
                bad++; $display("FAIL preempt_codes: first=%b second=%b len=%0d expected 100 010 1088",
                                wins[base].ev, wins[base+1].ev, wins[base+1].len);
            end
        end
    endtask

    task automatic test_dedup();
        int base;
        int exp_wins;
`ifdef SFX_DEDUP_EN
        exp_wins = 1;
`else
        exp_wins = 3;
`endif
        base = wins.size();
        game_running = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse(1'b1, 1'b0, 1'b0);
            run(39);
        end
        run(3700);
        total++;
        if (wins.size() - base !== exp_wins) begin
            bad++; $display("FAIL dedup_windows: got %0d expected %0d", wins.size() - base, exp_wins);
        end else begin
            for (int i = 0; i < exp_wins; i++) begin
                total++;
                if (wins[base+i].ev !== EV_JUMP || wins[base+i].len !== 1088) begin
                    bad++; $display("FAIL dedup_window%0d: code=%b len=%0d expected 001 1088", i, wins[base+i].ev, wins[base+i].len);
                end
            end
        end
    endtask

    task automatic test_not_running_and_reset();
        int base;
        base = wins.size();
        game_running = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        total++;
        if (queue_level !== 3'd0) begin
            bad++; $display("FAIL idle_jump_level: got %0d expected 0", queue_level);
        end
        run(20);
        total++;
        if (wins.size() - base !== 0 || event_jump !== 1'b0) begin
            bad++; $display("FAIL idle_jump_output: windows=%0d jump=%b expected 0 0", wins.size() - base, event_jump);
        end
        game_running = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        run(100);
        pulse(1'b0, 1'b0, 1'b1);
        total++;
        if (event_jump !== 1'b1 || queue_level !== 3'd1) begin
            bad++; $display("FAIL rst_setup: jump=%b level=%0d expected jump=1 level=1", event_jump, queue_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({event_highscore, event_death, event_jump} !== 3'b000 || queue_level !== 3'd0) begin
            bad++; $display("FAIL rst_mid_hold: outs=%b level=%0d expected outs=000 level=0",
                            {event_highscore, event_death, event_jump}, queue_level);
        end
        tick();
        base = wins.size();
        run(1300);
        total++;
        if (wins.size() - base !== 0 || {event_highscore, event_death, event_jump} !== 3'b000) begin
            bad++; $display("FAIL rst_no_replay: windows=%0d outs=%b expected 0 000",
                            wins.size() - base, {event_highscore, event_death, event_jump});
        end
    endtask

    initial begin
        test_reset();
        test_single_jump();
        test_same_cycle();
        test_overflow();
        test_death_preempt();
        test_dedup();
        test_not_running_and_reset();
        total++;
        if (multi_hot !== 0) begin
            bad++; $display("FAIL one_hot: got %0d multi-hot cycles expected 0", multi_hot);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
